// File: rtl/cpu_pkg.sv
// Shared MIPS32 pipeline definitions.
//   REG_W / XLEN / REG_ZERO : register-number width, datapath width, hard-wired zero register
//   idex_t                  : data fields held in the ID/EX pipeline register
//   dst_hit()               : true when a writing stage targets a given non-zero source
package cpu_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  opa;
        logic [XLEN-1:0]  opb;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] wdst;
        logic             wen;
        logic             is_load;
    } idex_t;

    // r0 never matches: it is constant zero and must not pick up forwarded data.
    function automatic logic dst_hit(input logic             wen,
                                     input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
        return wen && (dst == src) && (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Per-source operand selection and load-use hazard detection.
// Optional feature macro: WB_BYPASS_EN (adds the MEM/WB forwarding comparator).
// Ports:
//   i_src, i_uses                        source register and whether it is read
//   i_rf_data                            register-file read data
//   i_mem_wdst/wen/is_load, i_mem_data   EX/MEM producer
//   i_wb_wdst/wen, i_wb_data             MEM/WB producer (only with WB_BYPASS_EN)
//   i_ex_valid/wen/is_load, i_ex_wdst    instruction currently in ID/EX
//   o_operand                            selected operand value
//   o_load_hazard                        source depends on a load whose data is not ready
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0] i_src,
    input  logic             i_uses,
    input  logic [XLEN-1:0]  i_rf_data,
    input  logic [REG_W-1:0] i_mem_wdst,
    input  logic             i_mem_wen,
    input  logic             i_mem_is_load,
    input  logic [XLEN-1:0]  i_mem_data,
`ifdef WB_BYPASS_EN
    input  logic [REG_W-1:0] i_wb_wdst,
    input  logic             i_wb_wen,
    input  logic [XLEN-1:0]  i_wb_data,
`endif
    input  logic             i_ex_valid,
    input  logic             i_ex_wen,
    input  logic             i_ex_is_load,
    input  logic [REG_W-1:0] i_ex_wdst,
    output logic [XLEN-1:0]  o_operand,
    output logic             o_load_hazard
);

    logic w_src_nz;
    logic w_mem_fwd;
    logic w_mem_load_dep;
    logic w_ex_load_dep;

    assign w_src_nz = (i_src != REG_ZERO);

    // A load in EX/MEM has no data yet (mem_data is its address), so it is
    // never forwarded; it is reported as a hazard instead.
    assign w_mem_fwd      = dst_hit(i_mem_wen, i_mem_wdst, i_src) && !i_mem_is_load;
    assign w_mem_load_dep = dst_hit(i_mem_wen, i_mem_wdst, i_src) && i_mem_is_load;
    assign w_ex_load_dep  = dst_hit(i_ex_valid && i_ex_wen, i_ex_wdst, i_src) && i_ex_is_load;

    assign o_load_hazard = i_uses && (w_ex_load_dep || w_mem_load_dep);

`ifdef WB_BYPASS_EN
    logic w_wb_fwd;
    assign w_wb_fwd = dst_hit(i_wb_wen, i_wb_wdst, i_src);
`endif

    // MEM is the younger producer, so it wins over WB.
    always_comb begin
        o_operand = i_rf_data;
        if (!w_src_nz) begin
            o_operand = '0;
        end else if (w_mem_fwd) begin
            o_operand = i_mem_data;
`ifdef WB_BYPASS_EN
        end else if (w_wb_fwd) begin
            o_operand = i_wb_data;
`endif
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage: register-file addressing, EX/MEM and
// MEM/WB forwarding, load-use stall insertion and the ID/EX register with a
// valid/ready handshake toward EX.
// Optional feature macro: WB_BYPASS_EN. Without it the WB comparator is
// absent and the register file (written on negedge) supplies WB results.
// Ports:
//   clk, rst (async, active-high), flush
//   in_*        decoded instruction and its handshake (in_valid / in_ready)
//   rf_addr_*   register-file read addresses, rf_data_* read data
//   mem_*, wb_* producer information from EX/MEM and MEM/WB
//   out_*       ID/EX register contents and handshake (out_valid / out_ready)
//   stall_cnt   saturating count of hazard-stall cycles
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic              in_uses_rs,
    input  logic              in_uses_rt,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_W-1:0]  in_wdst,
    input  logic              in_wen,
    input  logic              in_is_load,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [REG_W-1:0]  rf_addr_a,
    output logic [REG_W-1:0]  rf_addr_b,
    input  logic [XLEN-1:0]   rf_data_a,
    input  logic [XLEN-1:0]   rf_data_b,
    input  logic [REG_W-1:0]  mem_wdst,
    input  logic              mem_wen,
    input  logic              mem_is_load,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [REG_W-1:0]  wb_wdst,
    input  logic              wb_wen,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_opa,
    output logic [XLEN-1:0]   out_opb,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_W-1:0]  out_wdst,
    output logic              out_wen,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    idex_t             r_idex_p1;
    logic [CTRL_W-1:0] r_ctrl_p1;
    logic              r_vld_p1;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [XLEN-1:0]   w_opa_p0;
    logic [XLEN-1:0]   w_opb_p0;
    logic              w_haz_a;
    logic              w_haz_b;
    logic              w_hazard;
    logic              w_xfer;

    assign rf_addr_a = in_rs;
    assign rf_addr_b = in_rt;

    fwd_mux u_fwd_a (
        .i_src         (in_rs),
        .i_uses        (in_uses_rs),
        .i_rf_data     (rf_data_a),
        .i_mem_wdst    (mem_wdst),
        .i_mem_wen     (mem_wen),
        .i_mem_is_load (mem_is_load),
        .i_mem_data    (mem_data),
`ifdef WB_BYPASS_EN
        .i_wb_wdst     (wb_wdst),
        .i_wb_wen      (wb_wen),
        .i_wb_data     (wb_data),
`endif
        .i_ex_valid    (r_vld_p1),
        .i_ex_wen      (r_idex_p1.wen),
        .i_ex_is_load  (r_idex_p1.is_load),
        .i_ex_wdst     (r_idex_p1.wdst),
        .o_operand     (w_opa_p0),
        .o_load_hazard (w_haz_a)
    );

    fwd_mux u_fwd_b (
        .i_src         (in_rt),
        .i_uses        (in_uses_rt),
        .i_rf_data     (rf_data_b),
        .i_mem_wdst    (mem_wdst),
        .i_mem_wen     (mem_wen),
        .i_mem_is_load (mem_is_load),
        .i_mem_data    (mem_data),
`ifdef WB_BYPASS_EN
        .i_wb_wdst     (wb_wdst),
        .i_wb_wen      (wb_wen),
        .i_wb_data     (wb_data),
`endif
        .i_ex_valid    (r_vld_p1),
        .i_ex_wen      (r_idex_p1.wen),
        .i_ex_is_load  (r_idex_p1.is_load),
        .i_ex_wdst     (r_idex_p1.wdst),
        .o_operand     (w_opb_p0),
        .o_load_hazard (w_haz_b)
    );

`ifndef WB_BYPASS_EN
    // WB results reach us through the register file in this build.
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_wdst, wb_wen, wb_data};
`endif

    assign w_hazard = in_valid && (w_haz_a || w_haz_b);
    // flush is folded into in_ready so a squashed instruction never transfers.
    assign in_ready = !w_hazard && !flush && (!r_vld_p1 || out_ready);
    assign w_xfer   = in_valid && in_ready;

    // ---- ID -> EX boundary: ID/EX pipeline register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_idex_p1 <= '0;
            r_ctrl_p1 <= '0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_xfer) begin
            r_vld_p1          <= 1'b1;
            r_idex_p1.pc      <= in_pc;
            r_idex_p1.opa     <= w_opa_p0;
            r_idex_p1.opb     <= w_opb_p0;
            r_idex_p1.imm     <= in_imm;
            r_idex_p1.wdst    <= in_wdst;
            r_idex_p1.wen     <= in_wen;
            r_idex_p1.is_load <= in_is_load;
            r_ctrl_p1         <= in_ctrl;
        end else if (out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid   = r_vld_p1;
    assign out_pc      = r_idex_p1.pc;
    assign out_opa     = r_idex_p1.opa;
    assign out_opb     = r_idex_p1.opb;
    assign out_imm     = r_idex_p1.imm;
    assign out_wdst    = r_idex_p1.wdst;
    assign out_wen     = r_idex_p1.wen;
    assign out_is_load = r_idex_p1.is_load;
    assign out_ctrl    = r_ctrl_p1;
    assign stall_cnt   = r_stall_cnt;

endmodule
